inst_sequencer: RTL

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/smachine_pkg.sv | 20 ++
 rtl/mem_port_mux.sv | 49 ++++
 rtl/inst_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/smachine_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// default halt opcode and default execution timeout.
package smachine_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    localparam logic [3:0] HALT_OP_DEFAULT      = 4'b1111;
    localparam int         EXEC_TIMEOUT_DEFAULT = 16;

    // True when an instruction's opcode field selects the halt operation.
    function automatic logic is_halt_op(input logic [3:0] opcode, input logic [3:0] halt_op);
        return (opcode == halt_op);
    endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Arbitration of the single shared memory port between instruction fetch
// and the execution unit's data accesses.
module mem_port_mux (
    input  logic        sel,
    input  logic        fetch_req,
    input  logic [7:0]  fetch_addr,
    input  logic        exec_req,
    input  logic        exec_we,
    input  logic [7:0]  exec_addr,
    input  logic [15:0] exec_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] exec_rdata,
    output logic        exec_ack
);

    // Route the port to the execution unit while executing, otherwise to fetch.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'h00;
        mem_wdata  = 16'h0000;
        exec_rdata = 16'h0000;
        exec_ack   = 1'b0;
        if (sel) begin
            mem_req    = exec_req;
            mem_we     = exec_we;
            mem_addr   = exec_addr;
            mem_wdata  = exec_wdata;
            exec_rdata = mem_rdata;
            exec_ack   = mem_ack;
        end else if (fetch_req) begin
            mem_req    = 1'b1;
            mem_we     = 1'b0;
            mem_addr   = fetch_addr;
            mem_wdata  = 16'h0000;
        end else begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = 8'h00;
            mem_wdata  = 16'h0000;
        end
    end

endmodule

// File: rtl/inst_sequencer.sv
// Fetch/issue/execute sequencer: fetches 16-bit instructions from a shared
// memory port, hands them to an external execution unit and tracks retirement.
module inst_sequencer
    import smachine_pkg::*;
#(
    parameter int         EXEC_TIMEOUT = EXEC_TIMEOUT_DEFAULT,
    parameter logic [3:0] HALT_OP      = HALT_OP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    input  logic        pc_load,
    input  logic [7:0]  pc_load_val,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] exec_inst,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        exec_mem_req,
    input  logic        exec_mem_we,
    input  logic [7:0]  exec_mem_addr,
    input  logic [15:0] exec_mem_wdata,
    output logic [15:0] exec_mem_rdata,
    output logic        exec_mem_ack,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] inst_count
);

    localparam int TW = $clog2(EXEC_TIMEOUT + 1);

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [7:0]    pc_r;
    logic [15:0]   inst_r;
    logic          exec_start_r;
    logic          step_flag_r;
    logic [TW-1:0] tmo_r;
    logic [15:0]   inst_count_r;
    logic          busy_r;
    logic          halted_r;
    logic          fault_r;
    logic          fetch_done_s;
    logic          retire_s;
    logic          tmo_last_s;
    logic          pc_load_ok_s;

    assign fetch_done_s = (state_r == ST_FETCH) && mem_ack;
    assign retire_s     = (state_r == ST_EXEC) && exec_done;
    assign tmo_last_s   = (tmo_r == TW'(EXEC_TIMEOUT - 1));
    assign pc_load_ok_s = pc_load && ((state_r == ST_IDLE) || (state_r == ST_HALT) ||
                                      (state_r == ST_FAULT));

    // Next-state decode; exec_done wins over a timeout landing on the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pc_load)
                    state_nxt_s = ST_IDLE;
                else if (run || step)
                    state_nxt_s = ST_FETCH;
                else
                    state_nxt_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (mem_ack)
                    state_nxt_s = ST_ISSUE;
                else
                    state_nxt_s = ST_FETCH;
            end
            ST_ISSUE: begin
                if (is_halt_op(inst_r[15:12], HALT_OP))
                    state_nxt_s = ST_HALT;
                else
                    state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done)
                    state_nxt_s = (run && !step_flag_r) ? ST_FETCH : ST_IDLE;
                else if (tmo_last_s)
                    state_nxt_s = ST_FAULT;
                else
                    state_nxt_s = ST_EXEC;
            end
            ST_HALT, ST_FAULT: begin
                if (pc_load)
                    state_nxt_s = ST_IDLE;
                else
                    state_nxt_s = state_r;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            busy_r   <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_ISSUE) ||
                        (state_nxt_s == ST_EXEC);
            halted_r <= (state_nxt_s == ST_HALT);
            fault_r  <= (state_nxt_s == ST_FAULT);
        end
    end

    // Program counter: external load when stopped, increment on each completed fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= 8'h00;
        end else if (pc_load_ok_s) begin
            pc_r <= pc_load_val;
        end else if (fetch_done_s) begin
            pc_r <= pc_r + 8'd1;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Instruction capture; exec_start is high exactly for the ISSUE cycle of a non-halt word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_r       <= 16'h0000;
            exec_start_r <= 1'b0;
        end else if (fetch_done_s) begin
            inst_r       <= mem_rdata;
            exec_start_r <= !is_halt_op(mem_rdata[15:12], HALT_OP);
        end else begin
            inst_r       <= inst_r;
            exec_start_r <= 1'b0;
        end
    end

    // Single-shot step flag: armed when leaving IDLE, cleared whenever the run stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_flag_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_FETCH)) begin
            step_flag_r <= step;
        end else if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_HALT) ||
                     (state_nxt_s == ST_FAULT)) begin
            step_flag_r <= 1'b0;
        end else begin
            step_flag_r <= step_flag_r;
        end
    end

    // Execution watchdog; held at zero outside EXEC so every entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_r <= '0;
        end else if (state_r == ST_EXEC) begin
            tmo_r <= tmo_r + TW'(1);
        end else begin
            tmo_r <= '0;
        end
    end

    // Retired-instruction counter, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_count_r <= 16'h0000;
        end else if (retire_s) begin
            inst_count_r <= inst_count_r + 16'd1;
        end else begin
            inst_count_r <= inst_count_r;
        end
    end

    mem_port_mux u_mux (
        .sel        (state_r == ST_EXEC),
        .fetch_req  (state_r == ST_FETCH),
        .fetch_addr (pc_r),
        .exec_req   (exec_mem_req),
        .exec_we    (exec_mem_we),
        .exec_addr  (exec_mem_addr),
        .exec_wdata (exec_mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .exec_rdata (exec_mem_rdata),
        .exec_ack   (exec_mem_ack)
    );

    assign pc         = pc_r;
    assign exec_inst  = inst_r;
    assign exec_start = exec_start_r;
    assign inst_count = inst_count_r;
    assign busy       = busy_r;
    assign halted     = halted_r;
    assign fault      = fault_r;

endmodule
